vector_processor: RTL

VECTOR_PROCESSOR -- requirements
Module: vector_processor

---
 rtl/vp_pkg.sv | 22 ++
 rtl/vp_isqrt.sv | 75 +++++++
 rtl/vector_processor.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/vp_pkg.sv
// Shared definitions for the vector processor: opcodes, fixed-point
// constants and FSM state encoding.
package vp_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DOT    = 4'd3;
  localparam logic [3:0] OP_SCALE  = 4'd4;
  localparam logic [3:0] OP_LENGTH = 4'd5;

  localparam logic [15:0] FP_ONE    = 16'h0100;
  localparam int unsigned FRAC_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LANE = 2'd1,
    ST_SQRT = 2'd2,
    ST_DONE = 2'd3
  } vp_state_e;

endpackage

// File: rtl/vp_isqrt.sv
// Restoring integer square root, one result bit per cycle.
// The first iteration is folded into the load cycle, so o_done pulses
// on the cycle after the seventeenth iteration edge.
module vp_isqrt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [33:0] i_rad,
  output logic        o_done,
  output logic [16:0] o_root
);

  logic [33:0] r_rad;
  logic [17:0] r_rem;
  logic [16:0] r_root;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;

  logic [33:0] w_rad;
  logic [17:0] w_rem_in;
  logic [16:0] w_root_in;
  logic [19:0] w_rem_sh;
  logic [19:0] w_trial;
  logic [17:0] w_rem_nxt;
  logic [16:0] w_root_nxt;

  // One restoring step on either the fresh operand or the running state.
  always_comb begin
    w_rad      = i_start ? i_rad : r_rad;
    w_rem_in   = i_start ? '0 : r_rem;
    w_root_in  = i_start ? '0 : r_root;
    w_rem_sh   = {w_rem_in, w_rad[33:32]};
    w_trial    = {1'b0, w_root_in, 2'b01};
    w_rem_nxt  = w_rem_sh[17:0];
    w_root_nxt = w_root_in << 1;
    if (w_rem_sh >= w_trial) begin
      w_rem_nxt  = 18'(w_rem_sh - w_trial);
      w_root_nxt = (w_root_in << 1) | 17'd1;
    end
  end

  // Iteration state and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rad  <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start || r_busy) begin
        r_rad  <= {w_rad[31:0], 2'b00};
        r_rem  <= w_rem_nxt;
        r_root <= w_root_nxt;
      end
      if (i_start) begin
        r_cnt  <= 5'd16;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_cnt <= r_cnt - 5'd1;
        if (r_cnt == 5'd1) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_root = r_root;

endmodule

// File: rtl/vector_processor.sv
// Four-lane 8.8 fixed-point vector unit sharing one multiplier across lanes.
// Optional LENGTH datapath (with vp_isqrt) is enabled by VP_LENGTH_EN.
module vector_processor
  import vp_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int VECTOR_WIDTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [3:0]                         operation,
  input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0] vec_a,
  input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0] vec_b,
  input  logic [DATA_WIDTH-1:0]              scalar,
  output logic                               busy,
  output logic                               done,
  output logic [VECTOR_WIDTH*DATA_WIDTH-1:0] result,
  output logic                               result_valid
);

  localparam int VW = VECTOR_WIDTH * DATA_WIDTH;
  localparam int LW = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = PW + 2;
  localparam int HI = DATA_WIDTH + FRAC_BITS;
`ifdef VP_LENGTH_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  vp_state_e r_state;
  vp_state_e w_state_nxt;

  logic [3:0]            r_op;
  logic [VW-1:0]         r_a;
  logic [VW-1:0]         r_b;
  logic [DATA_WIDTH-1:0] r_scalar;
  logic [LW-1:0]         r_lane;
  logic [AW-1:0]         r_acc;
  logic [VW-1:0]         r_work;
  logic [VW-1:0]         r_result;

  logic                  w_op_ok;
  logic                  w_sq_done;
  logic [DATA_WIDTH-1:0] w_lane_a;
  logic [DATA_WIDTH-1:0] w_lane_b;
  logic [DATA_WIDTH-1:0] w_abs_a;
  logic [DATA_WIDTH-1:0] w_mul_a;
  logic [DATA_WIDTH-1:0] w_mul_b;
  logic [PW-1:0]         w_prod;
  logic [DATA_WIDTH-1:0] w_prod_sat;
  logic [AW-1:0]         w_acc_nxt;
  logic [DATA_WIDTH-1:0] w_acc_sat;
  logic [DATA_WIDTH-1:0] w_lane_res;
  logic [VW-1:0]         w_work_nxt;

  assign w_op_ok = (operation <= OP_SCALE) || (LEN_EN && (operation == OP_LENGTH));

`ifdef VP_LENGTH_EN
  logic                  w_sq_start;
  logic [16:0]           w_root;
  logic [DATA_WIDTH-1:0] w_root_sat;

  // The radicand includes the lane-0 square being added this same cycle.
  assign w_sq_start = (r_state == ST_LANE) && (r_lane == '0) && (r_op == OP_LENGTH);
  assign w_root_sat = w_root[16] ? '1 : w_root[15:0];

  vp_isqrt u_isqrt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_sq_start),
    .i_rad   (w_acc_nxt),
    .o_done  (w_sq_done),
    .o_root  (w_root)
  );
`else
  assign w_sq_done = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and status outputs.
  always_comb begin
    w_state_nxt  = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = w_op_ok ? ST_LANE : ST_DONE;
      end
      ST_LANE: begin
        if (r_lane == '0)
          w_state_nxt = (LEN_EN && (r_op == OP_LENGTH)) ? ST_SQRT : ST_DONE;
      end
      ST_SQRT: begin
        if (w_sq_done) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        result_valid = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-lane datapath around the single shared multiplier.
  always_comb begin
    w_lane_a = r_a[r_lane*DATA_WIDTH +: DATA_WIDTH];
    w_lane_b = r_b[r_lane*DATA_WIDTH +: DATA_WIDTH];
    w_abs_a  = w_lane_a[DATA_WIDTH-1] ? (~w_lane_a + 1'b1) : w_lane_a;
    w_mul_a  = w_lane_a;
    w_mul_b  = w_lane_b;
    case (r_op)
      OP_SCALE:  w_mul_b = r_scalar;
      OP_LENGTH: begin
        w_mul_a = w_abs_a;
        w_mul_b = w_abs_a;
      end
      default: ;
    endcase
    w_prod     = PW'(w_mul_a) * PW'(w_mul_b);
    w_prod_sat = (|w_prod[PW-1:HI]) ? '1 : w_prod[HI-1:FRAC_BITS];
    w_acc_nxt  = r_acc + AW'(w_prod);
    w_acc_sat  = (|w_acc_nxt[AW-1:HI]) ? '1 : w_acc_nxt[HI-1:FRAC_BITS];
    case (r_op)
      OP_ADD:           w_lane_res = w_lane_a + w_lane_b;
      OP_SUB:           w_lane_res = w_lane_a - w_lane_b;
      OP_MUL, OP_SCALE: w_lane_res = w_prod_sat;
      default:          w_lane_res = '0;
    endcase
    w_work_nxt = r_work;
    w_work_nxt[r_lane*DATA_WIDTH +: DATA_WIDTH] = w_lane_res;
  end

  // Operand capture, lane sequencing, accumulation and result update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_scalar <= '0;
      r_lane   <= '0;
      r_acc    <= '0;
      r_work   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op     <= operation;
            r_a      <= vec_a;
            r_b      <= vec_b;
            r_scalar <= scalar;
            r_lane   <= LW'(VECTOR_WIDTH - 1);
            r_acc    <= '0;
            r_work   <= '0;
            if (!w_op_ok) r_result <= '0;
          end
        end
        ST_LANE: begin
          r_acc  <= w_acc_nxt;
          r_work <= w_work_nxt;
          r_lane <= r_lane - 1'b1;
          if (w_state_nxt == ST_DONE)
            r_result <= (r_op == OP_DOT) ?
                        {w_acc_sat, {(VW-DATA_WIDTH){1'b0}}} : w_work_nxt;
        end
        ST_SQRT: begin
`ifdef VP_LENGTH_EN
          if (w_sq_done) r_result <= {w_root_sat, {(VW-DATA_WIDTH){1'b0}}};
`endif
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule
